div_unit: RTL
=============

// Module: div_unit
// PURPOSE
//  Multi-cycle 32-bit integer divider (DIV/DIVU) in the EX stage of the STPU pipeline.
//  It is the requesting end of the pipeline stall handshake: stallreq_o feeds ctrl's
//  stallreq_from_ex, which freezes PC/IF/ID/EX (stall = 6'b001111) until ready_o.
//  Restoring algorithm, one quotient bit per cycle; result goes to HI (rem) / LO (quot).
// PARAMETERS
//  None; datapath fixed at 32 bits (quotient 32, remainder 32, result 64).
// PORTS
//  clk           in   1   pipeline clock, rising edge
//  rst           in   1   reset, asynchronous, active-high (`ResetEnable)
//  signed_div_i  in   1   1 = signed DIV, 0 = unsigned DIVU; sampled with start_i
//  opdata1_i     in   32  dividend; sampled with start_i in DIV_FREE
//  opdata2_i     in   32  divisor; sampled with start_i in DIV_FREE
//  start_i       in   1   division request; EX holds it high until ready_o
//  annul_i       in   1   cancel in-flight division (flush/exception)
//  result_o      out  64  {remainder[31:0], quotient[31:0]}; valid while ready_o
//  ready_o       out  1   result valid (`DivResultReady)
//  stallreq_o    out  1   to ctrl stallreq_from_ex; `Stop while division incomplete
// BEHAVIOUR
//  - Reset (async, any state): state=DIV_FREE, cnt=0, result_o=0, ready_o=0. stallreq_o
//    is combinational: start_i & ~annul_i & (state != DIV_END); so 0 once rst drops.
//  - States: DIV_FREE, DIV_BYZERO, DIV_ON, DIV_END (2-bit encoding, registered).
//  - DIV_FREE: if start_i & ~annul_i: divisor==0 -> DIV_BYZERO; else latch |operands|
//    (two's-complement negate if signed_div_i and operand negative), latch signs,
//    cnt<=0, -> DIV_ON. Otherwise stay; ready_o=0, result_o=0.
//  - DIV_BYZERO: next edge -> DIV_END, result_o=64'h0, ready_o=1.
//  - DIV_ON: annul_i -> DIV_FREE, ready_o=0, partial result discarded. Else while
//    cnt!=32: one restoring step (33-bit subtract of divisor from partial remainder;
//    borrow -> shift in 0, else keep difference and shift in 1), cnt<=cnt+1.
//    When cnt==32: sign-fix (quotient negated iff signed & signs differ; remainder
//    takes dividend sign), register result_o, ready_o<=1, -> DIV_END.
//  - Latency: start seen at edge E0 -> ready_o high after E33 (non-zero divisor),
//    after E1 (zero divisor). stallreq_o high from start_i rise until ready_o rises.
//  - DIV_END: hold result_o, ready_o=1 while start_i high. start_i low -> DIV_FREE,
//    ready_o<=0, result_o<=0. annul_i in DIV_END behaves as start_i low.
//  - Simultaneous start_i & annul_i in DIV_FREE: ignored, no state change.
//  - Operands are not re-sampled after DIV_FREE; changes mid-op have no effect.
//  - Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0 (natural wrap).
//  - Unsigned operands with bit31 set handled without sign fix (full 32-bit range).
// STRUCTURE
//  - defines.v gains: `DivFree 2'b00, `DivByZero 2'b01, `DivOn 2'b10, `DivEnd 2'b11,
//    `DivResultReady 1'b1, `DivResultNotReady 1'b0, `DivStart 1'b1, `DivStop 1'b0;
//    reuses existing `ResetEnable and `Stop / `NoStop.
//  - Single module; no sub-module warranted (step datapath is one 33-bit subtractor,
//    64+1-bit shift register, 6-bit counter, sign-fix negators).
// TESTING
//  1 DIVU 100/7, start held -> stallreq_o high 33 cycles; ready_o after E33;
//    result_o=64'h00000002_0000000E; stallreq_o low same cycle.
//  2 DIV -7/2 signed -> result_o={32'hFFFFFFFF, 32'hFFFFFFFD}; DIV 7/-2 -> {1, -3}.
//  3 DIV 0x80000000/0xFFFFFFFF -> {0, 32'h80000000}; DIVU 0xFFFFFFFF/1 -> {0, FFFFFFFF}.
//  4 Divisor 0 -> ready_o after E1, result_o=0, stallreq_o high exactly 1 cycle.
//  5 annul_i at cnt=10 -> DIV_FREE next edge, ready_o=0; restart 100/7 -> correct result.
//  6 rst asserted mid-DIV_ON (async, between edges) -> outputs 0 immediately; start_i
//    low -> stallreq_o=0; drop start_i in DIV_END -> ready_o, result_o return to 0.

Source files
------------

// File: rtl/div_unit_pkg.sv
// Shared types and helpers for the EX-stage multi-cycle divider.
// Holds the FSM encoding, handshake levels and operand sign helpers.
package div_unit_pkg;

    typedef enum logic [1:0] {
        DIV_FREE   = 2'b00,
        DIV_BYZERO = 2'b01,
        DIV_ON     = 2'b10,
        DIV_END    = 2'b11
    } div_state_e;

    localparam logic       DIV_RESULT_READY     = 1'b1;
    localparam logic       DIV_RESULT_NOT_READY = 1'b0;
    localparam logic       STOP                 = 1'b1;
    localparam logic       NO_STOP              = 1'b0;
    localparam logic [5:0] DIV_STEPS            = 6'd32;

    function automatic logic [31:0] neg32(input logic [31:0] v);
        return (~v) + 32'd1;
    endfunction

    function automatic logic [31:0] abs32(
        input logic        is_signed,
        input logic [31:0] v
    );
        return (is_signed && v[31]) ? neg32(v) : v;
    endfunction

endpackage

// File: rtl/div_unit.sv
// Restoring 32-bit divider for DIV/DIVU, one quotient bit per cycle.
// Raises a stall request to ctrl until the {rem, quot} result is ready.
module div_unit
    import div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    div_state_e  r_state;
    logic [5:0]  r_cnt;
    logic [31:0] r_rem;
    logic [31:0] r_quo;
    logic [31:0] r_divisor;
    logic        r_neg_quo;
    logic        r_neg_rem;

    logic        w_go;
    logic [32:0] w_partial;
    logic [32:0] w_diff;
    logic        w_borrow;
    logic [31:0] w_quo_fix;
    logic [31:0] w_rem_fix;

    assign w_go      = start_i & ~annul_i;
    assign w_partial = {r_rem, r_quo[31]};
    assign w_diff    = w_partial - {1'b0, r_divisor};
    assign w_borrow  = w_diff[32];
    assign w_quo_fix = r_neg_quo ? neg32(r_quo) : r_quo;
    assign w_rem_fix = r_neg_rem ? neg32(r_rem) : r_rem;

    assign stallreq_o = (w_go && r_state != DIV_END) ? STOP : NO_STOP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= DIV_FREE;
            r_cnt     <= '0;
            r_rem     <= '0;
            r_quo     <= '0;
            r_divisor <= '0;
            r_neg_quo <= 1'b0;
            r_neg_rem <= 1'b0;
            result_o  <= '0;
            ready_o   <= DIV_RESULT_NOT_READY;
        end else begin
            unique case (r_state)
                DIV_FREE: begin
                    result_o <= '0;
                    ready_o  <= DIV_RESULT_NOT_READY;
                    if (w_go) begin
                        if (opdata2_i == 32'd0) begin
                            r_state <= DIV_BYZERO;
                        end else begin
                            r_state   <= DIV_ON;
                            r_cnt     <= '0;
                            r_rem     <= '0;
                            r_quo     <= abs32(signed_div_i, opdata1_i);
                            r_divisor <= abs32(signed_div_i, opdata2_i);
                            r_neg_quo <= signed_div_i &
                                         (opdata1_i[31] ^ opdata2_i[31]);
                            r_neg_rem <= signed_div_i & opdata1_i[31];
                        end
                    end
                end
                DIV_BYZERO: begin
                    r_state  <= DIV_END;
                    result_o <= '0;
                    ready_o  <= DIV_RESULT_READY;
                end
                DIV_ON: begin
                    if (annul_i) begin
                        r_state <= DIV_FREE;
                        ready_o <= DIV_RESULT_NOT_READY;
                    end else if (r_cnt != DIV_STEPS) begin
                        // r_quo shifts the dividend out and the quotient in
                        r_rem <= w_borrow ? w_partial[31:0] : w_diff[31:0];
                        r_quo <= {r_quo[30:0], ~w_borrow};
                        r_cnt <= r_cnt + 6'd1;
                    end else begin
                        r_state  <= DIV_END;
                        result_o <= {w_rem_fix, w_quo_fix};
                        ready_o  <= DIV_RESULT_READY;
                    end
                end
                DIV_END: begin
                    if (!w_go) begin
                        r_state  <= DIV_FREE;
                        result_o <= '0;
                        ready_o  <= DIV_RESULT_NOT_READY;
                    end
                end
                default: r_state <= DIV_FREE;
            endcase
        end
    end

endmodule
